clk_fwd_diff: RTL and testbench
===============================

Name: clk_fwd_diff

Overview:
- Forwarded-clock transmitter. Derives a divided clock from the single-ended system clock and drives it off-chip as a registered complementary pair.
- Counterpart of the board's differential clock input stage. Feeds the output buffer pair (P/N pins) toward an external receiver.
- Provides glitch-free start/stop, a programmable divide and an edge strobe for data launch logic.

Parameters:
- DIV_W, 8, width of divide input; half-period = div+1 clk cycles
- IDLE_LVL, 0, level of clk_p while stopped; clk_n is always its complement

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin forwarding
- stop  input  1  single-cycle request to end forwarding
- div  input  DIV_W  half-period minus one, in clk cycles; sampled only on accepted start
- clk_p  output  1  forwarded clock, positive leg (registered)
- clk_n  output  1  forwarded clock, negative leg (registered, always ~clk_p)
- busy  output  1  high from accepted start until stop completes
- rise_stb  output  1  one-cycle pulse in the cycle clk_p becomes active (!IDLE_LVL)
- fall_stb  output  1  one-cycle pulse in the cycle clk_p returns to IDLE_LVL

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces the following:
  - clk_p=IDLE_LVL, clk_n=~IDLE_LVL, busy=0, rise_stb=0, fall_stb=0.
  - FSM=IDLE, half-period counter=0, div_q=0.
- FSM states are IDLE, RUN and DRAIN.
- IDLE, start=1:
  - Latch div into div_q, counter=0, busy=1, go RUN.
  - Next clock edge sets clk_p=!IDLE_LVL with rise_stb=1. Latency from start to the first active edge is 1 cycle.
- RUN:
  - Counter increments each cycle.
  - When counter==div_q: counter=0 and clk_p toggles. rise_stb or fall_stb pulses in the same cycle as the toggle.
  - div=0 gives clk/2. div=N gives period 2(N+1) cycles, 50% duty.
- RUN, stop=1 → DRAIN. Output continues unchanged.
- DRAIN:
  - The phase in progress runs to completion.
  - At the next point where clk_p would go active, the toggle is suppressed. clk_p stays IDLE_LVL, busy=0, go IDLE.
  - This guarantees the final idle-level phase is full width; no runt pulses.
- A stop in the cycle of the last active→idle toggle still waits out the full idle half-period.
- Changes on div while busy are ignored; the new value applies on the next start.
- Simultaneous start+stop:
  - In IDLE, start wins.
  - In RUN/DRAIN, stop is honoured and start is ignored.
- start while busy is ignored; no restart.
- stop in IDLE is ignored.
- clk_p and clk_n are both flops from the same next-state value, so the legs never differ by more than flop skew. No combinational path reaches either pin.
- rst_n asserted mid-operation: outputs go to reset values immediately (async). A runt pulse at reset is accepted.

Optional Feature:
- Macro: CLK_FWD_BURST_EN.
- With the macro defined:
  - Adds input burst_len [15:0] and output done (1-cycle pulse, reset 0).
  - burst_len is sampled on start. If nonzero, forwarding auto-stops after exactly burst_len active edges, via the normal DRAIN path.
  - done pulses in the cycle busy falls after an auto-stop or a manual stop.
  - burst_len=0 means free-running.
- Without the macro: no burst_len/done ports; forwarding runs until stop.

Test Plan:
- Reset then idle: hold rst_n=0 5 cycles, release → clk_p=0, clk_n=1, busy=0, no strobes for 20 cycles.
- div=0, pulse start at cycle 10:
  - busy=1 at 11; clk_p toggles every cycle from 11.
  - rise_stb at 11,13,15…; clk_n==~clk_p every cycle.
- div=3, start, stop asserted 2 cycles into a high phase:
  - High phase completes (4 cycles), then a full 4-cycle low phase.
  - clk_p stays 0, busy falls, no further rise_stb.
- div=2 running, drive div=7 mid-run: period stays 6 cycles. Stop, then restart → period 16 cycles.
- Same-cycle start+stop:
  - In IDLE → starts.
  - In RUN → drains.
  - Assert rst_n=0 while clk_p=1 → clk_p=0, clk_n=1, busy=0 immediately.
- CLK_FWD_BURST_EN defined, burst_len=5, div=1:
  - Exactly 5 rise_stb pulses, then a full low phase.
  - busy=0 and done=1 for one cycle; burst_len=0 free-runs 100 cycles.

Source files
------------

// File: rtl/clk_fwd_diff.sv
// Purpose : forwarded-clock transmitter; divides clk and drives a registered complementary pair off-chip.
// Latency : an accepted start makes clk_p active on the same edge, so the first active edge follows start by 1 cycle.
// Backpress: none; start/stop are single-cycle requests, and start is ignored while busy.
//
// Ports:
//   clk, rst_n          system clock (rising edge) and asynchronous active-low reset
//   start, stop         single-cycle requests to begin/end forwarding
//   div[DIV_W-1:0]      half-period minus one in clk cycles, captured on an accepted start
//   clk_p, clk_n        forwarded clock pair; both are flops fed from one next-state value
//   busy                high from the accepted start until the drain completes
//   rise_stb, fall_stb  one-cycle strobes aligned with clk_p going active / returning idle
//   burst_len, done     only with CLK_FWD_BURST_EN: auto-stop after burst_len active edges,
//                       done pulses in the cycle busy falls
//
// Optional feature macro: CLK_FWD_BURST_EN

module clk_fwd_diff #(
    parameter int   DIV_W    = 8,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
`ifdef CLK_FWD_BURST_EN
    input  logic [15:0]      burst_len,
    output logic             done,
`endif
    output logic             clk_p,
    output logic             clk_n,
    output logic             busy,
    output logic             rise_stb,
    output logic             fall_stb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             lvl_q, lvl_d;      // current clk_p level
    logic             clkn_q;
    logic             busy_q, busy_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             phase_end;
    logic             auto_stop;

`ifdef CLK_FWD_BURST_EN
    logic [15:0]      burst_q, burst_d;
    logic [15:0]      rcnt_q, rcnt_d;    // active edges produced in this run
    logic             done_q, done_d;

    // The last requested active edge has been produced; the rest of the run
    // then leaves through the ordinary drain path.
    assign auto_stop = (burst_q != 16'd0) && (rcnt_q == burst_q);
`else
    assign auto_stop = 1'b0;
`endif

    assign phase_end = (cnt_q == div_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        lvl_d   = lvl_q;
        busy_d  = busy_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`ifdef CLK_FWD_BURST_EN
        burst_d = burst_q;
        rcnt_d  = rcnt_q;
        done_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // start wins over a coincident stop here
                if (start) begin
                    state_d = ST_RUN;
                    div_d   = div;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    lvl_d   = ~IDLE_LVL;
                    rise_d  = 1'b1;
`ifdef CLK_FWD_BURST_EN
                    burst_d = burst_len;
                    rcnt_d  = 16'd1;
`endif
                end
            end
            ST_RUN, ST_DRAIN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (phase_end) begin
                    cnt_d = '0;
                    if (lvl_q != IDLE_LVL) begin
                        lvl_d  = IDLE_LVL;
                        fall_d = 1'b1;
                    end else if (state_q == ST_DRAIN) begin
                        // Idle phase has run its full width: suppress the
                        // rising toggle so no runt pulse reaches the pins.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
`ifdef CLK_FWD_BURST_EN
                        done_d  = 1'b1;
`endif
                    end else begin
                        lvl_d  = ~IDLE_LVL;
                        rise_d = 1'b1;
`ifdef CLK_FWD_BURST_EN
                        rcnt_d = rcnt_q + 16'd1;
`endif
                    end
                end
                if ((state_q == ST_RUN) && (stop || auto_stop)) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            lvl_q   <= IDLE_LVL;
            clkn_q  <= ~IDLE_LVL;
            busy_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            lvl_q   <= lvl_d;
            clkn_q  <= ~lvl_d;   // same source as clk_p keeps the legs aligned
            busy_q  <= busy_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef CLK_FWD_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= 16'd0;
            rcnt_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            burst_q <= burst_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
`endif

    assign clk_p    = lvl_q;
    assign clk_n    = clkn_q;
    assign busy     = busy_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;

endmodule

// File: tb/tb_clk_fwd_diff.sv
module tb_clk_fwd_diff;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] div;
    logic       clk_p;
    logic       clk_n;
    logic       busy;
    logic       rise_stb;
    logic       fall_stb;
`ifdef CLK_FWD_BURST_EN
    logic [15:0] burst_len;
    logic        done;
`endif

    int total = 0;
    int bad   = 0;

    clk_fwd_diff #(
        .DIV_W    (8),
        .IDLE_LVL (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .div      (div),
`ifdef CLK_FWD_BURST_EN
        .burst_len(burst_len),
        .done     (done),
`endif
        .clk_p    (clk_p),
        .clk_n    (clk_n),
        .busy     (busy),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a run is described by elapsed cycles t since the accepted start.
    // clk_p is active while (t / (div+1)) is even; the run ends at the first
    // multiple of the full period after a stop (or at burst_len periods).
    int m_t    = 0;
    int m_d    = 0;
    int m_end  = -1;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int per;
        int nxt;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_d    = 0;
            m_end  = -1;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_t    = 0;
                    m_d    = int'(div);
                    m_end  = -1;
`ifdef CLK_FWD_BURST_EN
                    if (burst_len != 16'd0) m_end = int'(burst_len) * 2 * (m_d + 1);
`endif
                end
            end else begin
                per = 2 * (m_d + 1);
                m_t = m_t + 1;
                if (stop) begin
                    nxt = (m_t / per + 1) * per;
                    if (m_end < 0 || nxt < m_end) m_end = nxt;
                end
                if (m_t == m_end) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int hp;
        int e_clk;
        hp    = m_d + 1;
        e_clk = (m_busy && ((m_t / hp) % 2 == 0)) ? 1 : 0;
        check("clk_p", int'(clk_p), e_clk);
        check("clk_n", int'(clk_n), 1 - e_clk);
        check("busy", int'(busy), int'(m_busy));
        check("rise_stb", int'(rise_stb), (m_busy && (m_t % (2 * hp) == 0)) ? 1 : 0);
        check("fall_stb", int'(fall_stb), (m_busy && (m_t % (2 * hp) == hp)) ? 1 : 0);
`ifdef CLK_FWD_BURST_EN
        check("done", int'(done), int'(m_done));
`endif
    end

    task automatic wait_idle(input int lim, input string name);
        int n;
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        check({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic measure_period(input int lim, output int per);
        int r0;
        int r1;
        r0 = -1;
        r1 = -1;
        for (int i = 0; i < lim; i++) begin
            if (rise_stb) begin
                if (r0 < 0) r0 = i;
                else if (r1 < 0) r1 = i;
            end
            tick();
        end
        per = (r1 < 0) ? -1 : (r1 - r0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          sc;
        int          per;
        int          nr;
        logic [15:0] pat_p;
        logic [15:0] pat_r;
        logic [15:0] pat_b;

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        div   = 8'd0;
`ifdef CLK_FWD_BURST_EN
        burst_len = 16'd0;
`endif
        repeat (5) tick();
        rst_n = 1'b1;

        // quiet after reset
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || rise_stb || fall_stb || clk_p || !clk_n) sc++;
        end
        check("idle_activity", sc, 0);
        check("idle_clk_n", int'(clk_n), 1);

        // div=0: clk/2, active edge one cycle after start; later div change ignored
        div   = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        div   = 8'd5;
        pat_p = '0;
        pat_r = '0;
        for (int i = 0; i < 8; i++) begin
            pat_p[i] = clk_p;
            pat_r[i] = rise_stb;
            tick();
        end
        check("div0_clk_p", int'(pat_p), 16'h0055);
        check("div0_rise", int'(pat_r), 16'h0055);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(10, "div0");

        // div=3: stop in the middle of a high phase
        div   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop  = 1'b0;
        pat_p = '0;
        pat_b = '0;
        nr    = 0;
        for (int i = 0; i < 10; i++) begin
            pat_p[i] = clk_p;
            pat_b[i] = busy;
            nr += int'(rise_stb);
            tick();
        end
        check("drain_clk_p", int'(pat_p), 16'h0001);
        check("drain_busy", int'(pat_b), 16'h001F);
        check("drain_rises", nr, 0);

        // div=2 then div=7 while busy (ignored) plus a start while busy
        div   = 8'd2;
        start = 1'b1;
        tick();
        div   = 8'd7;
        tick();
        start = 1'b0;
        measure_period(30, per);
        check("period_div2", per, 6);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(40, "div2");
        start = 1'b1;
        tick();
        start = 1'b0;
        measure_period(60, per);
        check("period_div7", per, 16);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(40, "div7");

        // start+stop together: idle -> starts, running -> drains
        div   = 8'd1;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_idle_busy", int'(busy), 1);
        check("ss_idle_clk_p", int'(clk_p), 1);
        repeat (3) tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_run_busy", int'(busy), 1);
        wait_idle(20, "ss_run");
        sc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) sc++;
        end
        check("ss_run_no_restart", sc, 0);

        // asynchronous reset while clk_p is high
        div   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_clk_p", int'(clk_p), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk_p", int'(clk_p), 0);
        check("arst_clk_n", int'(clk_n), 1);
        check("arst_busy", int'(busy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

`ifdef CLK_FWD_BURST_EN
        // burst of 5 active edges, then full low phase and done pulse
        burst_len = 16'd5;
        div       = 8'd1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        burst_len = 16'd0;
        nr = 0;
        sc = 0;
        for (int i = 0; i < 80; i++) begin
            nr += int'(rise_stb);
            sc += int'(done);
            if (!busy) break;
            tick();
        end
        check("burst_rises", nr, 5);
        check("burst_done_cnt", sc, 1);
        check("burst_idle", int'(busy), 0);
        tick();
        check("burst_done_clear", int'(done), 0);

        // burst_len=0 free-runs
        burst_len = 16'd0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) sc++;
            tick();
        end
        check("free_run_busy_drops", sc, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(20, "free_run");
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
